control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter HALT_OP, default 5'h1F, opcode that enters HALT.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sclr  input  1  synchronous clear, active-high.
REQ-005 run  input  1  step enable; 0 freezes the sequencer.
REQ-006 opcode  input  5  instruction register contents (IR output).
REQ-007 flag_z  input  1  registered zero flag.
REQ-008 flag_c  input  1  registered carry flag.
REQ-009 pc_out, pc_inc, pc_load  output  1 each  program counter drive-bus / increment / load-from-bus.
REQ-010 mar_en, ir_en  output  1 each  MAR load / IR load (IR captures bus[7:3]).
REQ-011 ram_out, ram_we  output  1 each  RAM drive-bus / write.
REQ-012 acc_en, acc_out, b_en  output  1 each  accumulator load / drive-bus, B register load.
REQ-013 alu_out, alu_sub, flag_en  output  1 each  ALU drive-bus, subtract select, flag register load.
REQ-014 out_en  output  1  output register load.
REQ-015 halt  output  1  high while in HALT.
REQ-016 tstate  output  3  current T-state index (0-5), debug.

Function
REQ-017 States: T0..T5 and HALT; state register is the only storage; strobes are combinational from state, opcode and flags.
REQ-018 At most one of pc_out, ram_out, acc_out, alu_out SHALL be high in any cycle.
REQ-019 run=0: state held, every strobe output 0; halt and tstate still reflect the held state.
REQ-020 T0: pc_out, mar_en; next T1.
REQ-021 T1: ram_out, ir_en, pc_inc; next T2; decode uses the opcode registered at this edge (visible from T2).
REQ-022 Opcodes: 00 NOP, 01 LDA, 02 ADD, 03 SUB, 04 STA, 05 LDI, 06 JMP, 07 JZ, 08 JC, 0E OUT, HALT_OP HLT; any other value executes as NOP.
REQ-023 NOP: T2 no strobes; next T0 (3 cycles total).
REQ-024 LDI: T2 pc_out, mar_en; T3 ram_out, acc_en, pc_inc; next T0.
REQ-025 LDA: T2 pc_out, mar_en; T3 ram_out, mar_en, pc_inc; T4 ram_out, acc_en; next T0.
REQ-026 ADD/SUB: T2-T3 as LDA; T4 ram_out, b_en; T5 alu_out, acc_en, flag_en, alu_sub=1 for SUB only; next T0.
REQ-027 STA: T2-T3 as LDA; T4 acc_out, ram_we; next T0.
REQ-028 JMP: T2 pc_out, mar_en; T3 ram_out, pc_load; next T0.
REQ-029 JZ/JC: T2 pc_out, mar_en; T3 if flag (flag_z for JZ, flag_c for JC) sampled in T3 is 1: ram_out, pc_load; else pc_inc only; next T0.
REQ-030 OUT: T2 acc_out, out_en; next T0.
REQ-031 HLT: T2 no strobes; next HALT; HALT holds with all strobes 0, halt=1, tstate=0, exited only by rst or sclr.
REQ-032 pc_inc and pc_load SHALL never be high in the same cycle.

Reset
REQ-033 rst=1: state forced to T0 immediately, independent of clk; halt=0, tstate=0; outputs show T0 decode (pc_out, mar_en high when run=1).
REQ-034 sclr=1 at a clock edge: state becomes T0 regardless of run or current state; sclr has priority over run.
REQ-035 rst asserted mid-instruction aborts it; no partial strobes after release beyond T0 decode.

Verification
REQ-036 rst pulse, run=1, opcode=05 across fetch -> tstate 0,1,2,3,0; T3 shows ram_out, acc_en, pc_inc.
REQ-037 opcode=02 vs 03 -> 6-cycle sequence; T5 alu_out, acc_en, flag_en high, alu_sub=0 / 1 respectively.
REQ-038 opcode=07, flag_z=1 -> T3 ram_out, pc_load; flag_z=0 -> T3 pc_inc only, pc_load=0.
REQ-039 opcode=1F -> halt=1 from 4th cycle, strobes 0 for 10 cycles; sclr pulse -> tstate=0, halt=0 next cycle.
REQ-040 opcode=01, run dropped in T3 for 3 cycles -> strobes 0, tstate held at 3; run=1 resumes T3 then T4.
REQ-041 rst asserted asynchronously in T4 of STA -> tstate=0 before next edge, ram_we=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a small accumulator CPU: a T-state register
// plus combinational strobe decode from state, opcode and flags.
module control_sequencer #(
    parameter logic [4:0] HALT_OP = 5'h1F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclr,
    input  logic       run,
    input  logic [4:0] opcode,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_en,
    output logic       ir_en,
    output logic       ram_out,
    output logic       ram_we,
    output logic       acc_en,
    output logic       acc_out,
    output logic       b_en,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flag_en,
    output logic       out_en,
    output logic       halt,
    output logic [2:0] tstate
);

    localparam logic [4:0] OpNop = 5'h00;
    localparam logic [4:0] OpLda = 5'h01;
    localparam logic [4:0] OpAdd = 5'h02;
    localparam logic [4:0] OpSub = 5'h03;
    localparam logic [4:0] OpSta = 5'h04;
    localparam logic [4:0] OpLdi = 5'h05;
    localparam logic [4:0] OpJmp = 5'h06;
    localparam logic [4:0] OpJz  = 5'h07;
    localparam logic [4:0] OpJc  = 5'h08;
    localparam logic [4:0] OpOut = 5'h0E;

    typedef enum logic [2:0] {
        StT0   = 3'd0,
        StT1   = 3'd1,
        StT2   = 3'd2,
        StT3   = 3'd3,
        StT4   = 3'd4,
        StT5   = 3'd5,
        StHalt = 3'd6
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_en;
        logic ir_en;
        logic ram_out;
        logic ram_we;
        logic acc_en;
        logic acc_out;
        logic b_en;
        logic alu_out;
        logic alu_sub;
        logic flag_en;
        logic out_en;
    } strobe_t;

    state_e  state_q, state_d;
    strobe_t st, st_gated;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StT0;
        end else if (sclr) begin
            state_q <= StT0;
        end else if (run) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        st      = '0;
        state_d = state_q;
        unique case (state_q)
            StT0: begin
                st.pc_out = 1'b1;
                st.mar_en = 1'b1;
                state_d   = StT1;
            end
            StT1: begin
                st.ram_out = 1'b1;
                st.ir_en   = 1'b1;
                st.pc_inc  = 1'b1;
                state_d    = StT2;
            end
            StT2: begin
                state_d = StT0;
                if (opcode == HALT_OP) begin
                    state_d = StHalt;
                end else begin
                    case (opcode)
                        OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp, OpJz, OpJc: begin
                            st.pc_out = 1'b1;
                            st.mar_en = 1'b1;
                            state_d   = StT3;
                        end
                        OpOut: begin
                            st.acc_out = 1'b1;
                            st.out_en  = 1'b1;
                        end
                        OpNop:   state_d = StT0;
                        default: state_d = StT0;
                    endcase
                end
            end
            StT3: begin
                state_d = StT0;
                case (opcode)
                    OpLdi: begin
                        st.ram_out = 1'b1;
                        st.acc_en  = 1'b1;
                        st.pc_inc  = 1'b1;
                    end
                    OpLda, OpAdd, OpSub, OpSta: begin
                        // operand byte is an address: reload MAR from RAM
                        st.ram_out = 1'b1;
                        st.mar_en  = 1'b1;
                        st.pc_inc  = 1'b1;
                        state_d    = StT4;
                    end
                    OpJmp: begin
                        st.ram_out = 1'b1;
                        st.pc_load = 1'b1;
                    end
                    OpJz: begin
                        st.ram_out = flag_z;
                        st.pc_load = flag_z;
                        st.pc_inc  = ~flag_z;
                    end
                    OpJc: begin
                        st.ram_out = flag_c;
                        st.pc_load = flag_c;
                        st.pc_inc  = ~flag_c;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT4: begin
                state_d = StT0;
                case (opcode)
                    OpLda: begin
                        st.ram_out = 1'b1;
                        st.acc_en  = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        st.ram_out = 1'b1;
                        st.b_en    = 1'b1;
                        state_d    = StT5;
                    end
                    OpSta: begin
                        st.acc_out = 1'b1;
                        st.ram_we  = 1'b1;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT5: begin
                state_d = StT0;
                if (opcode == OpAdd || opcode == OpSub) begin
                    st.alu_out = 1'b1;
                    st.acc_en  = 1'b1;
                    st.flag_en = 1'b1;
                    st.alu_sub = (opcode == OpSub);
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StT0;
        endcase
    end

    assign st_gated = run ? st : '0;

    assign pc_out  = st_gated.pc_out;
    assign pc_inc  = st_gated.pc_inc;
    assign pc_load = st_gated.pc_load;
    assign mar_en  = st_gated.mar_en;
    assign ir_en   = st_gated.ir_en;
    assign ram_out = st_gated.ram_out;
    assign ram_we  = st_gated.ram_we;
    assign acc_en  = st_gated.acc_en;
    assign acc_out = st_gated.acc_out;
    assign b_en    = st_gated.b_en;
    assign alu_out = st_gated.alu_out;
    assign alu_sub = st_gated.alu_sub;
    assign flag_en = st_gated.flag_en;
    assign out_en  = st_gated.out_en;

    assign halt   = (state_q == StHalt);
    assign tstate = halt ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expectations are queued with their
// stimulus, then popped and compared against the DUT outputs on the falling edge.
module tb_control_sequencer;

    localparam logic [13:0] PC_OUT  = 14'h0001;
    localparam logic [13:0] PC_INC  = 14'h0002;
    localparam logic [13:0] PC_LOAD = 14'h0004;
    localparam logic [13:0] MAR_EN  = 14'h0008;
    localparam logic [13:0] IR_EN   = 14'h0010;
    localparam logic [13:0] RAM_OUT = 14'h0020;
    localparam logic [13:0] RAM_WE  = 14'h0040;
    localparam logic [13:0] ACC_EN  = 14'h0080;
    localparam logic [13:0] ACC_OUT = 14'h0100;
    localparam logic [13:0] B_EN    = 14'h0200;
    localparam logic [13:0] ALU_OUT = 14'h0400;
    localparam logic [13:0] ALU_SUB = 14'h0800;
    localparam logic [13:0] FLAG_EN = 14'h1000;
    localparam logic [13:0] OUT_EN  = 14'h2000;

    logic       clk = 1'b0;
    logic       rst, sclr, run, flag_z, flag_c;
    logic [4:0] opcode;
    logic       pc_out, pc_inc, pc_load, mar_en, ir_en, ram_out, ram_we;
    logic       acc_en, acc_out, b_en, alu_out, alu_sub, flag_en, out_en, halt;
    logic [2:0] tstate;
    logic [17:0] obs;

    typedef struct {
        logic        run;
        logic        sclr;
        logic        fz;
        logic        fc;
        logic [17:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_total = 0;
    int   n_bad   = 0;

    control_sequencer #(.HALT_OP(5'h1F)) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .run(run), .opcode(opcode),
        .flag_z(flag_z), .flag_c(flag_c),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_en(mar_en),
        .ir_en(ir_en), .ram_out(ram_out), .ram_we(ram_we), .acc_en(acc_en),
        .acc_out(acc_out), .b_en(b_en), .alu_out(alu_out), .alu_sub(alu_sub),
        .flag_en(flag_en), .out_en(out_en), .halt(halt), .tstate(tstate)
    );

    always #5 clk = ~clk;

    assign obs = {halt, tstate, out_en, flag_en, alu_sub, alu_out, b_en, acc_out, acc_en,
                  ram_we, ram_out, ir_en, mar_en, pc_load, pc_inc, pc_out};

    // Bus-contention and PC-control exclusivity hold every cycle.
    always @(negedge clk) begin
        n_total++;
        if ($countones({pc_out, ram_out, acc_out, alu_out}) > 1 || (pc_inc && pc_load)) begin
            n_bad++;
            $display("FAIL bus_exclusive @%0t: got drivers=%b inc/load=%b%b want <=1 driver",
                     $time, {pc_out, ram_out, acc_out, alu_out}, pc_inc, pc_load);
        end
    end

    function automatic void push(logic r, logic s, logic z, logic c, logic h, int t,
                                 logic [13:0] sm, string nm);
        exp_t x;
        x.run  = r;
        x.sclr = s;
        x.fz   = z;
        x.fc   = c;
        x.v    = {h, t[2:0], sm};
        x.name = nm;
        exp_q.push_back(x);
    endfunction

    function automatic void push_fetch(logic z, logic c, string nm);
        push(1, 0, z, c, 0, 0, PC_OUT | MAR_EN, {nm, "_t0"});
        push(1, 0, z, c, 0, 1, RAM_OUT | IR_EN | PC_INC, {nm, "_t1"});
    endfunction

    task automatic test_reset();
        rst = 1; sclr = 0; run = 1; opcode = 5'h05; flag_z = 0; flag_c = 0;
        @(posedge clk); #1;
        push(1, 0, 0, 0, 0, 0, PC_OUT | MAR_EN, "reset_t0_decode");
        push(0, 0, 0, 0, 0, 0, 14'h0, "reset_run0");
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        e = exp_q.pop_front();
        run = e.run;
        #1;
        n_total++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        run = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_ldi();
        opcode = 5'h05;
        push_fetch(0, 0, "ldi");
        push(1, 0, 0, 0, 0, 2, PC_OUT | MAR_EN, "ldi_t2");
        push(1, 0, 0, 0, 0, 3, RAM_OUT | ACC_EN | PC_INC, "ldi_t3");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
            @(negedge clk);
            n_total++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_sub();
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? 5'h02 : 5'h03;
            push_fetch(0, 0, "alu");
            push(1, 0, 0, 0, 0, 2, PC_OUT | MAR_EN, "alu_t2");
            push(1, 0, 0, 0, 0, 3, RAM_OUT | MAR_EN | PC_INC, "alu_t3");
            push(1, 0, 0, 0, 0, 4, RAM_OUT | B_EN, "alu_t4");
            push(1, 0, 0, 0, 0, 5, ALU_OUT | ACC_EN | FLAG_EN | ((k == 1) ? ALU_SUB : 14'h0),
                 (k == 0) ? "add_t5" : "sub_t5");
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
                @(negedge clk);
                n_total++;
                if (obs !== e.v) begin
                    n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jumps();
        // {opcode, flag_z, flag_c, taken}
        logic [7:0] cases [5];
        cases[0] = {5'h07, 3'b101};
        cases[1] = {5'h07, 3'b010};
        cases[2] = {5'h08, 3'b011};
        cases[3] = {5'h08, 3'b100};
        cases[4] = {5'h06, 3'b001};
        for (int k = 0; k < 5; k++) begin
            opcode = cases[k][7:3];
            push_fetch(cases[k][2], cases[k][1], "jmp");
            push(1, 0, cases[k][2], cases[k][1], 0, 2, PC_OUT | MAR_EN, "jmp_t2");
            push(1, 0, cases[k][2], cases[k][1], 0, 3,
                 cases[k][0] ? (RAM_OUT | PC_LOAD) : PC_INC,
                 cases[k][0] ? "jmp_t3_taken" : "jmp_t3_not_taken");
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
                @(negedge clk);
                n_total++;
                if (obs !== e.v) begin
                    n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_short_ops();
        // OUT, NOP and an undefined opcode all finish in T2
        logic [4:0] ops [3];
        ops[0] = 5'h0E; ops[1] = 5'h00; ops[2] = 5'h0A;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            push_fetch(0, 0, "short");
            push(1, 0, 0, 0, 0, 2, (k == 0) ? (ACC_OUT | OUT_EN) : 14'h0,
                 (k == 0) ? "out_t2" : "nop_t2");
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
                @(negedge clk);
                n_total++;
                if (obs !== e.v) begin
                    n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lda_stall();
        opcode = 5'h01;
        push_fetch(0, 0, "lda");
        push(1, 0, 0, 0, 0, 2, PC_OUT | MAR_EN, "lda_t2");
        for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 0, 3, 14'h0, "lda_stall_t3");
        push(1, 0, 0, 0, 0, 3, RAM_OUT | MAR_EN | PC_INC, "lda_resume_t3");
        push(1, 0, 0, 0, 0, 4, RAM_OUT | ACC_EN, "lda_t4");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
            @(negedge clk);
            n_total++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sclr_mid();
        opcode = 5'h02;
        push_fetch(0, 0, "sclr_mid");
        push(1, 1, 0, 0, 0, 2, PC_OUT | MAR_EN, "sclr_mid_t2");
        push(1, 0, 0, 0, 0, 0, PC_OUT | MAR_EN, "sclr_mid_back_t0");
        push(1, 1, 0, 0, 0, 1, RAM_OUT | IR_EN | PC_INC, "sclr_mid_t1");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
            @(negedge clk);
            n_total++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        opcode = 5'h1F;
        push_fetch(0, 0, "hlt");
        push(1, 0, 0, 0, 0, 2, 14'h0, "hlt_t2");
        for (int k = 0; k < 10; k++) push(1, 0, 0, 0, 1, 0, 14'h0, "hlt_hold");
        // sclr wins even with run low
        push(0, 1, 0, 0, 1, 0, 14'h0, "hlt_sclr_cycle");
        push(0, 0, 0, 0, 0, 0, 14'h0, "hlt_cleared_t0");
        push(1, 0, 0, 0, 0, 0, PC_OUT | MAR_EN, "hlt_cleared_run");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
            @(negedge clk);
            n_total++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_rst_sta();
        opcode = 5'h04;
        sclr = 0;
        push(1, 0, 0, 0, 0, 2, PC_OUT | MAR_EN, "sta_t2");
        push(1, 0, 0, 0, 0, 3, RAM_OUT | MAR_EN | PC_INC, "sta_t3");
        // previous test left the sequencer in T1
        push(1, 0, 0, 0, 0, 1, RAM_OUT | IR_EN | PC_INC, "sta_t1");
        exp_q.push_front(exp_q.pop_back());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            run = e.run; sclr = e.sclr; flag_z = e.fz; flag_c = e.fc;
            @(negedge clk);
            n_total++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
        push(1, 0, 0, 0, 0, 4, ACC_OUT | RAM_WE, "sta_t4");
        push(1, 0, 0, 0, 0, 0, PC_OUT | MAR_EN, "sta_async_rst");
        push(1, 0, 0, 0, 0, 1, RAM_OUT | IR_EN | PC_INC, "sta_after_rst_t1");
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        #2 rst = 1;
        #1;
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        #1 rst = 0;
        @(posedge clk); #1;
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_sub();
        test_jumps();
        test_short_ops();
        test_lda_stall();
        test_sclr_mid();
        test_halt();
        test_async_rst_sta();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
